// File: rtl/vector_packer.sv
// Collects NUMBERS_AMOUNT serial words into one packed vector behind a valid/ready output register.
// Optional macro VECTOR_PACKER_LAST_EN adds data_last_i to close a short, zero-padded vector early.
module vector_packer #(
  parameter int NUMBERS_AMOUNT = 16,
  parameter int NUMBER_WIDTH   = 10
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NUMBER_WIDTH-1:0]                data_i,
  input  logic                                   data_valid_i,
`ifdef VECTOR_PACKER_LAST_EN
  input  logic                                   data_last_i,
`endif
  output logic                                   ready_o,
  output logic [NUMBERS_AMOUNT*NUMBER_WIDTH-1:0] data_o,
  output logic                                   data_valid_o,
  input  logic                                   ready_i
);

  localparam int VEC_W = NUMBERS_AMOUNT * NUMBER_WIDTH;
  localparam int CNT_W = (NUMBERS_AMOUNT > 1) ? $clog2(NUMBERS_AMOUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUMBERS_AMOUNT - 1);

  logic [CNT_W-1:0]        cnt_reg;
  logic [CNT_W-1:0]        cnt_next;
  logic [NUMBER_WIDTH-1:0] fill_reg [NUMBERS_AMOUNT-1];
  logic [VEC_W-1:0]        data_reg;
  logic                    valid_reg;
  logic [VEC_W-1:0]        vec_next;
  logic                    at_last;
  logic                    finish;
  logic                    in_beat;
  logic                    out_beat;
  logic                    complete;

  assign at_last = (cnt_reg == LAST_SLOT);

`ifdef VECTOR_PACKER_LAST_EN
  assign finish = at_last | data_last_i;
`else
  assign finish = at_last;
`endif

  // Stall only when the closing word would overwrite a vector the adder has not taken.
  assign ready_o  = !(finish & valid_reg & !ready_i);
  assign in_beat  = data_valid_i & ready_o;
  assign out_beat = valid_reg & ready_i;
  assign complete = in_beat & finish;

  always_comb begin
    cnt_next = cnt_reg;
    if (complete) begin
      cnt_next = '0;
    end else if (in_beat) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Slots 0..N-2 live in the fill buffer; the closing word goes straight to the output register.
  generate
    for (genvar gi = 0; gi < NUMBERS_AMOUNT - 1; gi++) begin : g_slot
      localparam logic [CNT_W-1:0] SLOT = CNT_W'(gi);

`ifdef VECTOR_PACKER_LAST_EN
      assign vec_next[gi*NUMBER_WIDTH +: NUMBER_WIDTH] =
        (SLOT < cnt_reg)  ? fill_reg[gi] :
        (SLOT == cnt_reg) ? data_i       : '0;
`else
      assign vec_next[gi*NUMBER_WIDTH +: NUMBER_WIDTH] = fill_reg[gi];
`endif

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          fill_reg[gi] <= '0;
        end else if (in_beat && !finish && (cnt_reg == SLOT)) begin
          fill_reg[gi] <= data_i;
        end
      end
    end
  endgenerate

`ifdef VECTOR_PACKER_LAST_EN
  assign vec_next[VEC_W-1 -: NUMBER_WIDTH] = at_last ? data_i : '0;
`else
  assign vec_next[VEC_W-1 -: NUMBER_WIDTH] = data_i;
`endif

  // A completing beat wins over an output beat so vectors can stream back-to-back.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (complete) begin
      data_reg  <= vec_next;
      valid_reg <= 1'b1;
    end else if (out_beat) begin
      valid_reg <= 1'b0;
    end
  end

  assign data_o       = data_reg;
  assign data_valid_o = valid_reg;

endmodule

// File: tb/tb_vector_packer.sv
// Scoreboard bench for vector_packer: stimulus pushes expected vectors, a negedge monitor pops on output beats.
module tb_vector_packer;

  localparam int N  = 16;
  localparam int W  = 10;
  localparam int VW = N * W;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic          data_valid_i = 1'b0;
  logic          data_last_i = 1'b0;
  logic          ready_o;
  logic [VW-1:0] data_o;
  logic          data_valid_o;
  logic          ready_i = 1'b1;

  vector_packer #(.NUMBERS_AMOUNT(N), .NUMBER_WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
`ifdef VECTOR_PACKER_LAST_EN
    .data_last_i  (data_last_i),
`endif
    .ready_o      (ready_o),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .ready_i      (ready_i)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  int            stalls = 0;
  bit            rand_rdy = 1'b0;
  logic [VW-1:0] exp_q[$];
  logic [W-1:0]  coll [N];
  int            idx = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference collector: words fill slots in order; a closing word zero-pads the slots above it.
  task automatic model_word(input logic [W-1:0] w, input bit last);
    logic [VW-1:0] v;
    coll[idx] = w;
    if (idx == N - 1 || last) begin
      v = '0;
      for (int k = 0; k <= idx; k++) v[k*W +: W] = coll[k];
      exp_q.push_back(v);
      idx = 0;
    end else begin
      idx++;
    end
  endtask

  function automatic logic [VW-1:0] fill_all(input logic [W-1:0] w);
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = w;
    return v;
  endfunction

  task automatic send(input logic [W-1:0] w, input bit last);
    int guard = 0;
    data_i = w;
    data_last_i = last;
    data_valid_i = 1'b1;
    @(negedge clk);
    while (!ready_o && guard < 500) begin
      guard++;
      @(negedge clk);
    end
    if (guard > 0) stalls++;
    if (guard >= 500) begin
      check("send_timeout", {{(VW-1){1'b0}}, ready_o}, {{(VW-1){1'b0}}, 1'b1});
    end else begin
      model_word(w, last);
    end
    @(posedge clk);
    #1;
    data_valid_i = 1'b0;
    data_last_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      guard++;
      idle(1);
    end
    check("drain_queue_empty", VW'(exp_q.size()), '0);
  endtask

  always @(negedge clk) begin
    if (rst_i && data_valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_vector: got %h expected none", data_o);
      end else begin
        check("vector", data_o, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] vec_a;
    int sum;

    // Reset state
    idle(2);
    check("reset_valid", VW'(data_valid_o), '0);
    check("reset_data", data_o, '0);
    rst_i = 1'b1;
    idle(1);
    check("reset_ready", VW'(ready_o), VW'(1));

    // 1..16 back-to-back
    for (int k = 1; k <= N; k++) begin
      send(W'(k), 1'b0);
      if (k == N - 1) check("t1_not_valid_early", VW'(data_valid_o), '0);
    end
    check("t1_valid_latency", VW'(data_valid_o), VW'(1));
    check("t1_slot0", VW'(data_o[0 +: W]), VW'(1));
    check("t1_slot15", VW'(data_o[(N-1)*W +: W]), VW'(16));
    sum = 0;
    for (int k = 0; k < N; k++) sum += int'(data_o[k*W +: W]);
    check("t1_sum", VW'(sum), VW'(136));

    // 32 consecutive words, no stalls
    stalls = 0;
    for (int k = 0; k < 2 * N; k++) send(W'(20 + k), 1'b0);
    check("t2_no_stall", VW'(stalls), '0);
    idle(2);

    // Backpressure: A all 5 held, B all 7 stalls on its closing word
    ready_i = 1'b0;
    stalls = 0;
    for (int k = 0; k < N; k++) send(W'(5), 1'b0);
    for (int k = 0; k < N - 1; k++) send(W'(7), 1'b0);
    check("t3_no_early_stall", VW'(stalls), '0);
    vec_a = fill_all(W'(5));
    data_i = W'(7);
    data_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3_ready_low", VW'(ready_o), '0);
      check("t3_hold_a", data_o, vec_a);
    end
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    @(negedge clk);
    check("t3_ready_back", VW'(ready_o), VW'(1));
    model_word(W'(7), 1'b0);
    @(posedge clk);
    #1;
    data_valid_i = 1'b0;
    check("t3_b_no_bubble", VW'(data_valid_o), VW'(1));
    check("t3_b_data", data_o, fill_all(W'(7)));
    idle(2);

    // Gappy input, random ready
    rand_rdy = 1'b1;
    for (int v = 0; v < 10; v++) begin
      for (int k = 0; k < N; k++) begin
        send(W'($urandom_range(0, 1023)), 1'b0);
        idle(1);
      end
    end
    rand_rdy = 1'b0;
    ready_i = 1'b1;
    drain();

    // Reset mid-operation with a pending vector and 7 partial words
    ready_i = 1'b0;
    for (int k = 0; k < N; k++) send(W'(300 + k), 1'b0);
    for (int k = 0; k < 7; k++) send(W'(400 + k), 1'b0);
    #1;
    rst_i = 1'b0;
    #1;
    check("t5_valid_async_drop", VW'(data_valid_o), '0);
    check("t5_data_cleared", data_o, '0);
    exp_q.delete();
    idx = 0;
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    for (int k = 0; k < N; k++) send(W'(100 + k), 1'b0);
    check("t5_fresh_slot0", VW'(data_o[0 +: W]), VW'(100));
    drain();

`ifdef VECTOR_PACKER_LAST_EN
    send(W'(3), 1'b0);
    send(W'(4), 1'b0);
    send(W'(5), 1'b1);
    check("t6_short_vector", data_o, VW'({W'(5), W'(4), W'(3)}));
    send(W'(9), 1'b1);
    check("t6_next_slot0", data_o, VW'(9));
    drain();
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vector_packer.md
Name: vector_packer

Overview:
- Upstream neighbour of pipeline_adder.
- Gathers NUMBERS_AMOUNT serial words, one per input handshake, into one packed vector.
- Presents the vector to the adder with a valid/ready handshake.
- Double-buffered (fill buffer plus output register), so the next vector fills while the previous one waits for the adder.

Parameters:
- NUMBERS_AMOUNT, 16, words per output vector; must be >= 2
- NUMBER_WIDTH, 10, bits per word

Ports:
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  asynchronous reset, active-low
- data_i  input  NUMBER_WIDTH  serial input word
- data_valid_i  input  1  data_i is valid
- ready_o  output  1  packer accepts data_i this cycle
- data_o  output  NUMBERS_AMOUNT*NUMBER_WIDTH  packed vector; slot k at bits [k*NUMBER_WIDTH +: NUMBER_WIDTH]
- data_valid_o  output  1  data_o holds a complete vector
- ready_i  input  1  downstream adder accepts data_o

Behaviour:
- Reset (rst_i = 0, asynchronous):
  - slot counter = 0; fill buffer = 0
  - data_o = 0; data_valid_o = 0
  - ready_o = 1 once rst_i deasserts
- Handshakes:
  - Input beat = data_valid_i & ready_o; output beat = data_valid_o & ready_i.
  - data_o and data_valid_o are registered and stable while data_valid_o = 1 and ready_i = 0.
- Slot order:
  - First word accepted after reset or after a vector completes goes to slot 0, then slot 1, and so on.
  - Counter range 0..NUMBERS_AMOUNT-1.
- Counter and fill buffer:
  - On an input beat with counter < NUMBERS_AMOUNT-1: write data_i into fill slot[counter]; counter +1.
  - On an input beat with counter = NUMBERS_AMOUNT-1 (completing beat):
    - load data_o from fill slots 0..N-2 plus data_i in slot N-1;
    - set data_valid_o = 1; counter wraps to 0;
    - fill buffer is not cleared; it is overwritten by subsequent words.
- Output register:
  - On an output beat with no simultaneous completing beat: data_valid_o -> 0 next cycle; data_o holds its last value.
  - Simultaneous output beat and completing beat: new vector loads; data_valid_o stays 1, giving back-to-back vectors with no bubble.
- Backpressure:
  - ready_o = !(counter == NUMBERS_AMOUNT-1 & data_valid_o & !ready_i).
  - ready_o drops only when the completing word would overwrite an unconsumed vector.
  - Combinational path ready_i -> ready_o is permitted.
  - data_valid_i may drop at any cycle; gaps do not affect the counter.
- Latency: completing beat on cycle t gives data_valid_o = 1 on cycle t+1.
- Throughput: one word per cycle sustained when ready_i = 1.
- Arithmetic: no arithmetic; words pass unmodified and zero-extension is not applied.
- Reset mid-operation:
  - Partial vector and pending output are discarded.
  - data_valid_o drops asynchronously; no stale vector is emitted after reset.

Optional Feature:
- Macro: VECTOR_PACKER_LAST_EN
- With macro:
  - Adds input port data_last_i (1 bit), sampled on input beats.
  - An input beat with data_last_i = 1 is a completing beat regardless of counter.
  - Slots above the current one are loaded as zero, so a downstream sum of a short vector stays correct.
  - Counter wraps to 0.
  - ready_o rule becomes: ready_o = !(data_valid_o & !ready_i & (counter == NUMBERS_AMOUNT-1 | data_last_i)).
- Without macro: no data_last_i port; vectors complete only at NUMBERS_AMOUNT words.

Test Plan:
- Reset, then 16 words 1..16 sent back-to-back with ready_i = 1 -> data_valid_o = 1 one cycle after the 16th beat; slot 0 = 1, slot 15 = 16; a downstream sum equals 136.
- 32 consecutive words with ready_i = 1 -> two vectors with data_valid_o high on consecutive completing cycles; ready_o never drops.
- Fill vector A (all 5); hold ready_i = 0; send 16 words of 7 -> ready_o drops only while the 16th 7 is offered; vector A (all 5) stays on data_o unchanged until ready_i = 1; vector B (all 7) follows next cycle.
- data_valid_i toggling 1/0 every cycle with random ready_i, 10 vectors of random 10-bit words -> scoreboard match of every vector in order; no word lost or duplicated.
- rst_i pulsed low after 7 words accepted and while a vector is pending -> data_valid_o = 0 immediately; next 16 words form a fresh vector starting at slot 0.
- VECTOR_PACKER_LAST_EN: words 3, 4, 5 with data_last_i = 1 on the 5 -> vector slots 0..2 = 3, 4, 5, slots 3..15 = 0; next word lands in slot 0.
